// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bundle between the EXE stage and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, stall, done, div_zero, hi, lo
    );

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, stall, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiply / restoring divide that owns HI/LO and stalls the
// pipeline until the result is committed.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    muldiv_sequencer_if.slave  bus
);
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_a_q, neg_a_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [IW-1:0]      iter_q, iter_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               a_neg, b_neg;
    logic               div_by_zero;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] div_sh;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_raw;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        a_neg       = ~bus.op[1] & bus.src_a[WIDTH-1];
        b_neg       = ~bus.op[1] & bus.src_b[WIDTH-1];
        div_by_zero = (b_q == '0);
        mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
        div_sh      = acc_q << 1;
        div_trial   = {1'b0, div_sh[2*WIDTH-1:WIDTH]} - {1'b0, b_q};
        prod_fix    = neg_res_q ? -acc_q : acc_q;
        // A zero divisor leaves the dividend as remainder; re-applying its sign restores src_a.
        quo_fix     = div_by_zero ? '1 :
                      (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        rem_raw     = div_by_zero ? a_q : acc_q[2*WIDTH-1:WIDTH];
        rem_fix     = neg_a_q ? -rem_raw : rem_raw;
    end

    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        a_d       = a_q;
        b_d       = b_q;
        neg_res_d = neg_res_q;
        neg_a_d   = neg_a_q;
        acc_d     = acc_q;
        iter_d    = iter_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    state_d   = S_PREP;
                    is_div_d  = bus.op[0];
                    a_d       = a_neg ? -bus.src_a : bus.src_a;
                    b_d       = b_neg ? -bus.src_b : bus.src_b;
                    neg_res_d = a_neg ^ b_neg;
                    neg_a_d   = a_neg;
                end
            end
            S_PREP: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    iter_d  = '0;
                    // Low half carries the multiplier (multiply) or dividend (divide) into RUN.
                    acc_d   = is_div_q ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{1'b0}}, b_q};
                    state_d = (is_div_q && div_by_zero) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_d = div_trial[WIDTH] ? div_sh
                              : {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    iter_d = iter_q + IW'(1);
                    if (iter_q == IW'(WIDTH-1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                        dz_d = div_by_zero;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            is_div_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            acc_q     <= '0;
            iter_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            a_q       <= a_d;
            b_q       <= b_d;
            neg_res_q <= neg_res_d;
            neg_a_q   <= neg_a_d;
            acc_q     <= acc_d;
            iter_q    <= iter_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.stall    = (bus.start & ~bus.flush & (state_q == S_IDLE)) | busy_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic/latency model checked every cycle
// plus hand-computed expectations for each directed vector.
module tb_muldiv_sequencer;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   stall_cnt = 0;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the MIPS HI/LO definitions.
    function automatic void model_calc(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b, output logic [31:0] h,
                                       output logic [31:0] l, output logic dz);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        dz = 1'b0;
        h  = '0;
        l  = '0;
        case (op)
            2'b00: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
            2'b10: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    dz = 1'b1; h = a; l = '1;
                end else if (op == 2'b01) begin
                    sq = sa / sb; sr = sa % sb; h = sr[31:0]; l = sq[31:0];
                end else begin
                    up = ua / ub; h = 32'(ua % ub); l = up[31:0];
                end
            end
        endcase
    endfunction

    logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        p_dz = 1'b0;
    int          m_left = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0; m_left = 0;
        end else begin
            m_done = 0;
            m_dz   = 0;
            if (!m_busy) begin
                if (bus.start && !bus.flush) begin
                    model_calc(bus.op, bus.src_a, bus.src_b, p_hi, p_lo, p_dz);
                    m_left = p_dz ? 2 : W + 2;
                    m_busy = 1;
                end
            end else if (bus.flush) begin
                m_busy = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_hi = p_hi; m_lo = p_lo; m_done = 1; m_dz = p_dz;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy",     64'(bus.busy),     64'(m_busy));
        chk("stall",    64'(bus.stall),    64'((bus.start & ~bus.flush & ~m_busy) | m_busy));
        chk("done",     64'(bus.done),     64'(m_done));
        chk("div_zero", 64'(bus.div_zero), 64'(m_dz));
        chk("hi",       64'(bus.hi),       64'(m_hi));
        chk("lo",       64'(bus.lo),       64'(m_lo));
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
        @(negedge clk);
        stall_cnt = bus.stall ? 1 : 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = -1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (bus.done) begin cyc = c; break; end
            if (bus.stall) stall_cnt++;
            @(posedge clk); #1;
        end
        if (cyc < 0) begin
            checks++; errors++;
            $display("FAIL wait_done: no done within %0d cycles", limit);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        int          cyc;
    } vec_t;

    vec_t vecs[$] = '{
        '{2'b10, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 35},
        '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 35},
        '{2'b01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 35},
        '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       35},
        '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 35},
        '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 35},
        '{2'b01, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 35},
        '{2'b01, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 35},
        '{2'b11, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 35},
        '{2'b11, 32'd5,        32'd10,       32'd5,        32'd0,        35},
        '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 35},
        '{2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 3}
    };

    initial begin
        int cyc;
        int done_seen;
        bus.start = 0; bus.op = '0; bus.src_a = '0; bus.src_b = '0; bus.flush = 0;
        #22 rst = 1'b1;
        @(negedge clk);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset hi",   64'(bus.hi),   64'd0);
        chk("reset lo",   64'(bus.lo),   64'd0);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(60, cyc);
            chk($sformatf("v%0d done cycle", i), 64'(cyc), 64'(vecs[i].cyc));
            chk($sformatf("v%0d stall cycles", i), 64'(stall_cnt), 64'(vecs[i].cyc));
            chk($sformatf("v%0d hi", i), 64'(bus.hi), 64'(vecs[i].hi));
            chk($sformatf("v%0d lo", i), 64'(bus.lo), 64'(vecs[i].lo));
            chk($sformatf("v%0d div_zero", i), 64'(bus.div_zero), 64'(vecs[i].b == 0 && vecs[i].op[0]));
        end

        // Flush at cycle 10, with an ignored start at cycle 5.
        issue(2'b00, 32'd7, 32'd9);
        repeat (4) begin @(posedge clk); #1; end
        bus.start = 1; bus.op = 2'b10; bus.src_a = 32'hDEADBEEF; bus.src_b = 32'd3;
        @(posedge clk); #1;
        bus.start = 0;
        repeat (4) begin @(posedge clk); #1; end
        bus.flush = 1;
        @(posedge clk); #1;
        bus.flush = 0;
        chk("flush busy", 64'(bus.busy), 64'd0);
        chk("flush hi", 64'(bus.hi), 64'd100);
        chk("flush lo", 64'(bus.lo), 64'hFFFFFFFF);
        done_seen = 0;
        repeat (40) begin @(negedge clk); if (bus.done) done_seen++; end
        chk("flush no done", 64'(done_seen), 64'd0);

        // start and flush together in IDLE.
        @(posedge clk); #1;
        bus.start = 1; bus.flush = 1;
        @(negedge clk);
        chk("start+flush stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        bus.start = 0; bus.flush = 0;
        chk("start+flush busy", 64'(bus.busy), 64'd0);

        issue(2'b00, 32'd7, 32'd9);
        wait_done(60, cyc);
        chk("7*9 cycle", 64'(cyc), 64'd35);
        chk("7*9 lo", 64'(bus.lo), 64'd63);

        // Flush in the FIX cycle (cycle 34).
        issue(2'b10, 32'd2, 32'd3);
        repeat (33) begin @(posedge clk); #1; end
        bus.flush = 1;
        @(posedge clk); #1;
        bus.flush = 0;
        chk("fix flush done", 64'(bus.done), 64'd0);
        chk("fix flush lo", 64'(bus.lo), 64'd63);

        // Asynchronous reset mid-RUN.
        issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (13) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        chk("async rst busy", 64'(bus.busy), 64'd0);
        chk("async rst hi", 64'(bus.hi), 64'd0);
        chk("async rst lo", 64'(bus.lo), 64'd0);
        @(negedge clk); #2 rst = 1'b1;

        issue(2'b01, 32'h80000000, 32'hFFFFFFFF);
        wait_done(60, cyc);
        chk("minint/-1 cycle", 64'(cyc), 64'd35);
        chk("minint/-1 lo", 64'(bus.lo), 64'h80000000);
        chk("minint/-1 hi", 64'(bus.hi), 64'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
